// File: rtl/mld_15_7_type2_decoder.sv
// Serial Type-II majority-logic decoder for the (15,7) cyclic code, g(x) = 1 + x^4 + x^6 + x^7 + x^8.
// Optional bit_corrected output enabled by defining MLD_15_7_CORR_FLAG_EN.
module mld_15_7_type2_decoder (
   input  logic clk,
   input  logic reset,
   input  logic in_bit,
   input  logic in_valid,
   output logic data_out,
   output logic out_valid
`ifdef MLD_15_7_CORR_FLAG_EN
   ,
   output logic bit_corrected
`endif
);

   typedef enum logic {S_IDLE, S_DECODE} state_t;

   state_t      r_state;
   logic [14:0] r_rx;
   logic [14:0] r_dec;
   logic [3:0]  r_rx_cnt;
   logic [2:0]  r_step;

   logic [4:0]  w_est;
   logic [2:0]  w_votes;
   logic        w_maj;
   logic        w_word_done;

   assign w_word_done = in_valid && (r_rx_cnt == 4'd14);

   // Five orthogonal estimates of the bit currently at dec[14]
   always_comb begin
      w_est   = '0;
      w_est[0] = r_dec[0] ^ r_dec[2]  ^ r_dec[6];
      w_est[1] = r_dec[1] ^ r_dec[5]  ^ r_dec[13];
      w_est[2] = r_dec[3] ^ r_dec[11] ^ r_dec[12];
      w_est[3] = r_dec[7] ^ r_dec[8]  ^ r_dec[10];
      w_est[4] = r_dec[14];
      w_votes = {2'b00, w_est[0]} + {2'b00, w_est[1]} + {2'b00, w_est[2]}
              + {2'b00, w_est[3]} + {2'b00, w_est[4]};
      w_maj   = (w_votes >= 3'd3);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_rx      <= '0;
         r_dec     <= '0;
         r_rx_cnt  <= '0;
         r_step    <= '0;
         data_out  <= 1'b0;
         out_valid <= 1'b0;
`ifdef MLD_15_7_CORR_FLAG_EN
         bit_corrected <= 1'b0;
`endif
      end else begin
         if (in_valid) begin
            r_rx     <= {r_rx[13:0], in_bit};
            r_rx_cnt <= w_word_done ? 4'd0 : r_rx_cnt + 4'd1;
         end

         data_out  <= 1'b0;
         out_valid <= 1'b0;
`ifdef MLD_15_7_CORR_FLAG_EN
         bit_corrected <= 1'b0;
`endif

         if (r_state == S_DECODE) begin
            data_out  <= w_maj;
            out_valid <= 1'b1;
`ifdef MLD_15_7_CORR_FLAG_EN
            bit_corrected <= w_maj ^ r_dec[14];
`endif
            r_dec  <= {r_dec[13:0], w_maj};
            r_step <= r_step + 3'd1;
            if (r_step == 3'd6)
               r_state <= S_IDLE;
         end

         // A freshly completed word overrides the decode bookkeeping above
         if (w_word_done) begin
            r_dec   <= {r_rx[13:0], in_bit};
            r_step  <= '0;
            r_state <= S_DECODE;
         end
      end
   end

endmodule

// File: tb/tb_mld_15_7_type2_decoder.sv
// Self-checking bench for mld_15_7_type2_decoder; reference decodes by nearest-codeword search.
module tb_mld_15_7_type2_decoder;

   logic clk = 1'b0;
   logic reset;
   logic in_bit;
   logic in_valid;
   logic data_out;
   logic out_valid;
`ifdef MLD_15_7_CORR_FLAG_EN
   logic bit_corrected;
`endif

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;

   typedef struct {
      logic data;
      logic corr;
      int   cyc;
   } exp_t;

   exp_t q[$];

   mld_15_7_type2_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .data_out  (data_out),
      .out_valid (out_valid)
`ifdef MLD_15_7_CORR_FLAG_EN
      ,
      .bit_corrected (bit_corrected)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Systematic encoding: parity = (msg * x^8) mod g(x)
   function automatic logic [14:0] encode(input logic [6:0] msg);
      logic [14:0] t;
      logic [14:0] g;
      g = 15'h01D1;
      t = {msg, 8'h00};
      for (int i = 14; i >= 8; i--)
         if (t[i]) t = t ^ (g << (i - 8));
      return {msg, t[7:0]};
   endfunction

   function automatic logic [6:0] ref_decode(input logic [14:0] r);
      int unsigned best;
      int unsigned d;
      logic [6:0]  bm;
      logic [6:0]  m7;
      best = 99;
      bm   = '0;
      for (int unsigned m = 0; m < 128; m++) begin
         m7 = m[6:0];
         d  = $countones(encode(m7) ^ r);
         if (d < best) begin
            best = d;
            bm   = m7;
         end
      end
      return bm;
   endfunction

   // Output monitor: every out_valid cycle must match the next expected bit at its expected cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("data_out", 32'(data_out), 32'(e.data));
               chk("out_cycle", 32'(cyc), 32'(e.cyc));
`ifdef MLD_15_7_CORR_FLAG_EN
               chk("bit_corrected", 32'(bit_corrected), 32'(e.corr));
`endif
            end
         end else begin
`ifdef MLD_15_7_CORR_FLAG_EN
            chk("corr_idle_zero", 32'(bit_corrected), 32'd0);
`endif
            if (q.size() != 0 && q[0].cyc <= cyc) begin
               chk("missing_out_valid", 32'(out_valid), 32'd1);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic send_word(input logic [14:0] w, input int nbits, input int gap_at, input int gap_len);
      logic [6:0] dm;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_bit   = w[14-i];
         if (i == 14) begin
            dm = ref_decode(w);
            for (int k = 0; k < 7; k++) begin
               exp_t e;
               e.data = dm[6-k];
               e.corr = dm[6-k] ^ w[14-k];
               e.cyc  = cyc + 2 + k;
               q.push_back(e);
            end
         end
         if (i == gap_at) begin
            repeat (gap_len) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_bit   = 1'($urandom);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_bit   = 1'b0;
      end
   endtask

   localparam logic [14:0] CW_A = 15'b100000011101000;

   initial begin
      logic [14:0] w;
      logic [6:0]  m;
      int unsigned nerr;
      int unsigned p1;
      int unsigned p2;

      reset    = 1'b1;
      in_bit   = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("reset_data_out", 32'(data_out), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
`ifdef MLD_15_7_CORR_FLAG_EN
      chk("reset_bit_corrected", 32'(bit_corrected), 32'd0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(2);

      send_word(CW_A, 15, -1, 0);
      idle(10);
      send_word(15'b000000011101000, 15, -1, 0);
      idle(10);
      send_word(15'b101000011100000, 15, -1, 0);
      idle(10);

      send_word(15'b0, 15, -1, 0);
      send_word(CW_A, 15, -1, 0);
      idle(10);

      send_word(CW_A, 15, 6, 5);
      idle(10);

      send_word(CW_A, 8, -1, 0);
      idle(1);
      reset = 1'b1;
      #1;
      chk("rst_rx_out_valid", 32'(out_valid), 32'd0);
      idle(2);
      reset = 1'b0;
      idle(20);
      send_word(CW_A, 15, -1, 0);
      idle(10);

      send_word(CW_A, 15, -1, 0);
      idle(3);
      chk("pre_async_out_valid", 32'(out_valid), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_data_out", 32'(data_out), 32'd0);
      q.delete();
      idle(1);
      reset = 1'b0;
      idle(10);

      for (int n = 0; n < 40; n++) begin
         m    = 7'($urandom);
         w    = encode(m);
         nerr = $urandom_range(0, 2);
         p1   = $urandom_range(0, 14);
         p2   = (p1 + $urandom_range(1, 14)) % 15;
         if (nerr >= 1) w[p1] = ~w[p1];
         if (nerr == 2) w[p2] = ~w[p2];
         if ($urandom_range(0, 2) == 0)
            send_word(w, 15, int'($urandom_range(0, 13)), int'($urandom_range(1, 4)));
         else
            send_word(w, 15, -1, 0);
         if ($urandom_range(0, 3) == 0)
            idle(int'($urandom_range(1, 6)));
      end

      idle(20);
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/mld_15_7_type2_decoder.md
# mld_15_7_type2_decoder

Serial Type-II majority-logic decoder for the (15,7) cyclic code, g(x) = 1 + x^4 + x^6 + x^7 + x^8. It is the receive-side counterpart of the (15,7) serial encoder. It accepts the channel bit stream in transmission order: r14 first, message bits r14..r8, then parity r7..r0. It corrects up to two bit errors per word and emits the 7 decoded message bits serially. Receive and decode are ping-pong buffered, so back-to-back words stream without gaps.

## Interface
Parameters:
- none. Code length 15, message length 7 and the check sums are fixed.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_bit  in  1  received channel bit.
- in_valid  in  1  in_bit is sampled on each rising edge where in_valid=1.
- data_out  out  1  decoded message bit, registered.
- out_valid  out  1  data_out is valid this cycle.
- bit_corrected  out  1  present only with MLD_15_7_CORR_FLAG_EN (see Configuration).

## Operation
- Receive shift register rx[14:0]: on each valid bit, rx <= {rx[13:0], in_bit}. A 4-bit counter rx_cnt counts 0..14.
- On the edge that samples the 15th bit:
  - {rx[13:0], in_bit} is copied to decode buffer dec[14:0]; dec[14]=r14, dec[0]=r0.
  - rx_cnt returns to 0.
  - The decode FSM is started.
- Decode FSM states:
  - IDLE: waiting for a word.
  - DECODE: 7 steps, tracked by a 3-bit step counter.
  - DECODE returns to IDLE after step 6. If a new word lands on that same edge, the FSM enters DECODE again directly.
- Each decode step:
  - Form the five estimates of dec[14]:
    - B1 = d0^d2^d6
    - B2 = d1^d5^d13
    - B3 = d3^d11^d12
    - B4 = d7^d8^d10
    - B5 = d14
  - maj = 1 when 3 or more of the five estimates are 1. Ties are impossible.
  - data_out <= maj; out_valid <= 1.
  - dec <= {dec[13:0], maj}: a cyclic shift that writes the corrected bit back into the buffer.
- Output order is u6..u0, the same order the message bits were transmitted. The parity positions are never output.
- Words with 3 or more errors can be miscorrected. There is no detection or signalling for this case.
- Overrun is structurally impossible: a word needs at least 15 cycles to arrive and decoding takes 7 cycles. No overflow logic is required.
- Gaps in in_valid are allowed anywhere, including within a word. The partial word is held unchanged during a gap.

## Timing
- Reset values:
  - data_out=0, out_valid=0, bit_corrected=0.
  - rx=0, rx_cnt=0, dec=0.
  - FSM in IDLE.
- Let edge N be the edge that samples the 15th bit of a word.
  - Decode steps occur on edges N+1 through N+7.
  - out_valid is high for exactly 7 consecutive cycles, from after edge N+1 until edge N+8.
  - Latency from the last input bit to the first output bit is 1 clock.
- Continuous input (in_valid held at 1): a word completes every 15 cycles, giving 7 out_valid cycles followed by 8 idle cycles.
- A receive in progress during DECODE does not disturb dec.
- Reset asserted mid-receive or mid-decode:
  - All outputs drop immediately; no clock edge is needed.
  - The partial or in-flight word is discarded.
  - After reset deasserts, the next valid bit is treated as r14 of a new word.

## Configuration
- MLD_15_7_CORR_FLAG_EN:
  - Defined: adds port bit_corrected. It is registered alongside data_out and equals maj ^ dec[14] for that step, so it is 1 when the decoder flipped that message bit. It is 0 whenever out_valid=0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset with inputs idle -> data_out=0 and out_valid=0. Assert reset asynchronously mid-cycle -> outputs clear with no clock edge.
- Error-free codeword 100000011101000 (r14 first), in_valid held high -> one cycle after the 15th bit, 7 out_valid cycles carry 1,0,0,0,0,0,0. bit_corrected is 0 throughout (flag build).
- Single error, r14 flipped: send 000000011101000 -> output 1,0,0,0,0,0,0. bit_corrected=1 on the first output bit only.
- Double error, r12 and r3 flipped: send 101000011100000 -> output 1,0,0,0,0,0,0.
- Back-to-back words over 30 cycles with in_valid held high: the all-zero word, then 100000011101000 -> outputs 0000000 then 1000000, each decoded at the documented edges, with no lost or extra out_valid.
- Stall and reset:
  - Deassert in_valid for 5 cycles after bit 6 -> the word still decodes correctly.
  - Assert reset after 8 bits of a word -> no out_valid appears. The next full word, 100000011101000, decodes to 1000000.
